// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache in front of main_mem: 4 lines x 4 words of 32 bits.
// Latency: a hit is answered from the COMPARE state, so cpu_ready is high in the second cycle after the request cycle.
//          A miss first writes back a dirty victim (4 words) if needed, refills (4 words), then re-runs COMPARE.
// Backpressure: cpu_req is only sampled in IDLE, so requests during busy must be held or re-presented.
//          Memory stalls follow the level "done" signal, with no timeout.
// Ports: cpu_* is the requester side; *_mem, read_data_mem and done form the one-word-per-transaction main_mem port.
module cache_ctrl #(
    parameter int ADDR_W         = 10,
    parameter int NUM_LINES      = 4,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_hit,
    output logic              busy,
    output logic              read_write_mem,
    output logic [ADDR_W-1:0] address_mem,
    output logic [31:0]       write_data_mem,
    input  logic [31:0]       read_data_mem,
    input  logic              done
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
    localparam int WA_W  = ADDR_W - 2;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COMPARE, S_WB_ISSUE, S_WB_WAIT, S_RF_ISSUE, S_RF_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [OFF_W-1:0]        cnt_q, cnt_d;
    logic                    seen_low_q, seen_low_d;    // done has been observed low in this WAIT
    logic                    post_fill_q, post_fill_d;  // current COMPARE pass follows a refill
    logic                    req_rw_q, req_rw_d;
    logic [WA_W-1:0]         req_waddr_q, req_waddr_d;  // word address, byte offset dropped
    logic [31:0]             req_wdata_q, req_wdata_d;
    logic [NUM_LINES-1:0]    valid_q, valid_d, dirty_q, dirty_d;
    logic [31:0]             cpu_rdata_q, cpu_rdata_d;
    logic                    cpu_ready_q, cpu_ready_d, cpu_hit_q, cpu_hit_d, busy_q, busy_d;
    logic                    rw_mem_q, rw_mem_d;
    logic [ADDR_W-1:0]       addr_mem_q, addr_mem_d;
    logic [31:0]             wdata_mem_q, wdata_mem_d;

    // Tag and data storage carry no reset; valid_q gates their use.
    logic [TAG_W-1:0]        tag_q  [NUM_LINES];
    logic [31:0]             data_q [NUM_LINES*WORDS_PER_LINE];

    logic                    tag_we, data_we;
    logic [IDX_W+OFF_W-1:0]  data_waddr;
    logic [31:0]             data_wdat;

    logic [TAG_W-1:0]        req_tag;
    logic [IDX_W-1:0]        req_idx;
    logic [OFF_W-1:0]        req_off;
    logic                    lookup_hit;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[1:0];

    assign req_tag    = req_waddr_q[WA_W-1 -: TAG_W];
    assign req_idx    = req_waddr_q[OFF_W +: IDX_W];
    assign req_off    = req_waddr_q[OFF_W-1:0];
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seen_low_d  = seen_low_q;
        post_fill_d = post_fill_q;
        req_rw_d    = req_rw_q;
        req_waddr_d = req_waddr_q;
        req_wdata_d = req_wdata_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        cpu_hit_d   = cpu_hit_q;
        rw_mem_d    = rw_mem_q;
        addr_mem_d  = addr_mem_q;
        wdata_mem_d = wdata_mem_q;
        tag_we      = 1'b0;
        data_we     = 1'b0;
        data_waddr  = {req_idx, req_off};
        data_wdat   = req_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    req_rw_d    = cpu_rw;
                    req_waddr_d = cpu_addr[ADDR_W-1:2];
                    req_wdata_d = cpu_wdata;
                    post_fill_d = 1'b0;
                    state_d     = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (lookup_hit) begin
                    cpu_ready_d = 1'b1;
                    cpu_hit_d   = !post_fill_q;
                    if (req_rw_q) begin
                        data_we          = 1'b1;
                        dirty_d[req_idx] = 1'b1;
                    end else begin
                        cpu_rdata_d = data_q[{req_idx, req_off}];
                    end
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WB_ISSUE : S_RF_ISSUE;
                end
            end
            S_WB_ISSUE: begin
                wdata_mem_d = data_q[{req_idx, cnt_q}];
                rw_mem_d    = 1'b1;
                addr_mem_d  = {tag_q[req_idx], req_idx, cnt_q, 2'b00};
                seen_low_d  = 1'b0;
                state_d     = S_WB_WAIT;
            end
            S_WB_WAIT: begin
                // done is a level: only a high seen after a low ends the transaction.
                if (!seen_low_q) begin
                    seen_low_d = !done;
                end else if (done) begin
                    if (cnt_q == LAST_WORD) begin
                        dirty_d[req_idx] = 1'b0;
                        cnt_d            = '0;
                        state_d          = S_RF_ISSUE;
                    end else begin
                        cnt_d   = cnt_q + OFF_W'(1);
                        state_d = S_WB_ISSUE;
                    end
                end
            end
            S_RF_ISSUE: begin
                rw_mem_d   = 1'b0;
                addr_mem_d = {req_tag, req_idx, cnt_q, 2'b00};
                seen_low_d = 1'b0;
                state_d    = S_RF_WAIT;
            end
            S_RF_WAIT: begin
                if (!seen_low_q) begin
                    seen_low_d = !done;
                end else if (done) begin
                    data_we    = 1'b1;
                    data_waddr = {req_idx, cnt_q};
                    data_wdat  = read_data_mem;
                    if (cnt_q == LAST_WORD) begin
                        valid_d[req_idx] = 1'b1;
                        dirty_d[req_idx] = 1'b0;
                        tag_we           = 1'b1;
                        post_fill_d      = 1'b1;
                        state_d          = S_COMPARE;
                    end else begin
                        cnt_d   = cnt_q + OFF_W'(1);
                        state_d = S_RF_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            seen_low_q  <= 1'b0;
            post_fill_q <= 1'b0;
            req_rw_q    <= 1'b0;
            req_waddr_q <= '0;
            req_wdata_q <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            cpu_hit_q   <= 1'b0;
            busy_q      <= 1'b0;
            rw_mem_q    <= 1'b0;
            addr_mem_q  <= '0;
            wdata_mem_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seen_low_q  <= seen_low_d;
            post_fill_q <= post_fill_d;
            req_rw_q    <= req_rw_d;
            req_waddr_q <= req_waddr_d;
            req_wdata_q <= req_wdata_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_hit_q   <= cpu_hit_d;
            busy_q      <= busy_d;
            rw_mem_q    <= rw_mem_d;
            addr_mem_q  <= addr_mem_d;
            wdata_mem_q <= wdata_mem_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_q[data_waddr] <= data_wdat;
        if (tag_we)  tag_q[req_idx]     <= req_tag;
    end

    assign cpu_rdata      = cpu_rdata_q;
    assign cpu_ready      = cpu_ready_q;
    assign cpu_hit        = cpu_hit_q;
    assign busy           = busy_q;
    assign read_write_mem = rw_mem_q;
    assign address_mem    = addr_mem_q;
    assign write_data_mem = wdata_mem_q;

endmodule
